// File: rtl/route_inject_stage_pkg.sv
// Shared flit layout, slot count and output-port indices for the route/inject stage.
// Flit: [15] valid, [14:13] dest Y, [12:11] dest X, [10:0] src/mshr/seq pass-through.
package route_inject_stage_pkg;

    localparam int unsigned STEER_W    = 16;
    localparam int unsigned RMATRIX_W  = 4;
    localparam int unsigned VALID_F    = 15;
    localparam int unsigned DEST_X_LSB = 11;
    localparam int unsigned DEST_X_W   = 2;
    localparam int unsigned DEST_Y_W   = 2;
    localparam int unsigned NUM_SLOTS  = 4;

    typedef logic [STEER_W-1:0]   steer_t;
    typedef logic [RMATRIX_W-1:0] rmatrix_t;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_E = 2'd1,
        PORT_S = 2'd2,
        PORT_W = 2'd3
    } port_e;

    // Port 0 maps to the MSB of the rmatrix, port 3 to the LSB.
    function automatic logic [1:0] rm_bit(port_e p);
        return 2'(RMATRIX_W - 1) - p;
    endfunction

endpackage

// File: rtl/route_inject_stage_route_calc.sv
// Combinational productive-port mask for one slot flit; invalid or local flits give 4'b0000.
module route_calc
    import route_inject_stage_pkg::*;
#(
    parameter int unsigned X_W  = DEST_X_W,
    parameter int unsigned Y_W  = DEST_Y_W,
    parameter int unsigned MY_X = 0,
    parameter int unsigned MY_Y = 0
) (
    input  logic [STEER_W-1:0]   flit,
    output logic [RMATRIX_W-1:0] rmatrix
);

    localparam logic [X_W-1:0] MY_X_C = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_C = Y_W'(MY_Y);

    logic [X_W-1:0] dest_x;
    logic [Y_W-1:0] dest_y;

    assign dest_x = flit[DEST_X_LSB +: X_W];
    assign dest_y = flit[DEST_X_LSB + X_W +: Y_W];

    always_comb begin
        rmatrix = '0;
        if (flit[VALID_F]) begin
            if (dest_y > MY_Y_C) rmatrix[rm_bit(PORT_N)] = 1'b1;
            if (dest_x > MY_X_C) rmatrix[rm_bit(PORT_E)] = 1'b1;
            if (dest_y < MY_Y_C) rmatrix[rm_bit(PORT_S)] = 1'b1;
            if (dest_x < MY_X_C) rmatrix[rm_bit(PORT_W)] = 1'b1;
        end
    end

endmodule

// File: rtl/route_inject_stage.sv
// Slot registers ahead of the deflection sortnet: eject one local flit, inject one local flit, route.
// Optional injection-starvation detector enabled by defining ROUTE_INJECT_STARVE_EN.
module route_inject_stage
    import route_inject_stage_pkg::*;
#(
    parameter int unsigned X_W          = DEST_X_W,
    parameter int unsigned Y_W          = DEST_Y_W,
    parameter int unsigned MY_X         = 0,
    parameter int unsigned MY_Y         = 0,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STEER_W-1:0]   link_in0,
    input  logic [STEER_W-1:0]   link_in1,
    input  logic [STEER_W-1:0]   link_in2,
    input  logic [STEER_W-1:0]   link_in3,
    input  logic [STEER_W-1:0]   inj_flit,
    input  logic                 inj_valid,
    output logic                 inj_ready,
    output logic [STEER_W-1:0]   eject_flit,
    output logic                 eject_valid,
    output logic [STEER_W-1:0]   control0_out,
    output logic [STEER_W-1:0]   control1_out,
    output logic [STEER_W-1:0]   control2_out,
    output logic [STEER_W-1:0]   control3_out,
    output logic [RMATRIX_W-1:0] rmatrix0_out,
    output logic [RMATRIX_W-1:0] rmatrix1_out,
    output logic [RMATRIX_W-1:0] rmatrix2_out,
    output logic [RMATRIX_W-1:0] rmatrix3_out,
    output logic                 starve
);

    localparam logic [X_W-1:0] MY_X_C = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_C = Y_W'(MY_Y);

    steer_t               slot_q [NUM_SLOTS];
    steer_t               slot_d [NUM_SLOTS];
    steer_t               ctrl   [NUM_SLOTS];
    rmatrix_t             rm     [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] local_hit;
    steer_t               eject_flit_q, eject_flit_d;
    logic                 eject_valid_q, eject_valid_d;
    logic                 eject_hit, inj_done;

    always_comb begin
        slot_d[0] = link_in0;
        slot_d[1] = link_in1;
        slot_d[2] = link_in2;
        slot_d[3] = link_in3;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            local_hit[i] = slot_q[i][VALID_F]
                        && (slot_q[i][DEST_X_LSB +: X_W] == MY_X_C)
                        && (slot_q[i][DEST_X_LSB + X_W +: Y_W] == MY_Y_C);
        end
    end

    // Eject first, then derive readiness from the post-eject view so an ejected slot can be refilled.
    always_comb begin
        eject_hit    = 1'b0;
        inj_done     = 1'b0;
        inj_ready    = 1'b0;
        eject_flit_d = eject_flit_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            ctrl[i] = slot_q[i];
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (local_hit[i] && !eject_hit) begin
                eject_hit        = 1'b1;
                eject_flit_d     = slot_q[i];
                ctrl[i][VALID_F] = 1'b0;
            end
        end
        eject_valid_d = eject_hit;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!ctrl[i][VALID_F]) inj_ready = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (inj_valid && !inj_done && !ctrl[i][VALID_F]) begin
                ctrl[i]  = inj_flit;
                inj_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            eject_flit_q  <= '0;
            eject_valid_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
            eject_flit_q  <= eject_flit_d;
            eject_valid_q <= eject_valid_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_route
        route_calc #(
            .X_W  (X_W),
            .Y_W  (Y_W),
            .MY_X (MY_X),
            .MY_Y (MY_Y)
        ) u_route_calc (
            .flit    (ctrl[g]),
            .rmatrix (rm[g])
        );
    end

    assign eject_flit   = eject_flit_q;
    assign eject_valid  = eject_valid_q;
    assign control0_out = ctrl[0];
    assign control1_out = ctrl[1];
    assign control2_out = ctrl[2];
    assign control3_out = ctrl[3];
    assign rmatrix0_out = rm[0];
    assign rmatrix1_out = rm[1];
    assign rmatrix2_out = rm[2];
    assign rmatrix3_out = rm[3];

`ifdef ROUTE_INJECT_STARVE_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inj_valid || inj_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_cnt_q <= '0;
        else     starve_cnt_q <= starve_cnt_d;
    end

    assign starve = (starve_cnt_q == LIMIT_C);
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_route_inject_stage.sv
// Randomized self-checking bench for route_inject_stage against a queue-based reference model.
module tb_route_inject_stage;
    import route_inject_stage_pkg::*;

    localparam int MX    = 1;
    localparam int MY    = 1;
    localparam int LIMIT = 4;

    logic     clk = 1'b0;
    logic     rst;
    steer_t   lnk_i [4];
    steer_t   inj_flit;
    logic     inj_valid;
    logic     inj_ready;
    steer_t   eject_flit;
    logic     eject_valid;
    steer_t   ctrl_o [4];
    rmatrix_t rm_o [4];
    logic     starve;

    route_inject_stage #(
        .X_W          (2),
        .Y_W          (2),
        .MY_X         (MX),
        .MY_Y         (MY),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .link_in0     (lnk_i[0]),
        .link_in1     (lnk_i[1]),
        .link_in2     (lnk_i[2]),
        .link_in3     (lnk_i[3]),
        .inj_flit     (inj_flit),
        .inj_valid    (inj_valid),
        .inj_ready    (inj_ready),
        .eject_flit   (eject_flit),
        .eject_valid  (eject_valid),
        .control0_out (ctrl_o[0]),
        .control1_out (ctrl_o[1]),
        .control2_out (ctrl_o[2]),
        .control3_out (ctrl_o[3]),
        .rmatrix0_out (rm_o[0]),
        .rmatrix1_out (rm_o[1]),
        .rmatrix2_out (rm_o[2]),
        .rmatrix3_out (rm_o[3]),
        .starve       (starve)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state and stimulus for the current cycle
    steer_t m_slot [4];
    logic   m_ejv;
    steer_t m_ejf;
    int     m_cnt;
    logic   nx_ejv;
    steer_t nx_ejf;
    int     nx_cnt;
    steer_t lnk [4];
    logic   iv;
    steer_t iflit;
    logic   chk_en;
    logic   exp_ready;

    function automatic steer_t mk(input bit v, input int x, input int y);
        steer_t f;
        logic [1:0] xs, ys;
        f  = steer_t'($urandom);
        xs = 2'(x);
        ys = 2'(y);
        f[VALID_F] = v;
        f[DEST_X_LSB +: 2]     = xs;
        f[DEST_X_LSB + 2 +: 2] = ys;
        return f;
    endfunction

    function automatic bit is_local(input steer_t f);
        return f[VALID_F] && (int'(f[DEST_X_LSB +: 2]) == MX) && (int'(f[DEST_X_LSB + 2 +: 2]) == MY);
    endfunction

    function automatic rmatrix_t ref_rm(input steer_t f);
        int dx, dy;
        if (!f[VALID_F]) return 4'b0000;
        dx = int'(f[DEST_X_LSB +: 2]) - MX;
        dy = int'(f[DEST_X_LSB + 2 +: 2]) - MY;
        return {dy > 0, dx > 0, dy < 0, dx < 0};
    endfunction

    function automatic steer_t rand_link();
        if ($urandom_range(7) == 0) return mk(0, $urandom_range(3), $urandom_range(3));
        if ($urandom_range(3) == 0) return mk(1, MX, MY);
        return mk(1, $urandom_range(3), $urandom_range(3));
    endfunction

    task automatic apply();
        steer_t e_ctrl [4];
        int locals[$];
        int frees[$];
        for (int i = 0; i < 4; i++) lnk_i[i] = lnk[i];
        inj_valid = iv;
        inj_flit  = iflit;
        #1;
        for (int i = 0; i < 4; i++) begin
            e_ctrl[i] = m_slot[i];
            if (is_local(m_slot[i])) locals.push_back(i);
        end
        if (locals.size() > 0) e_ctrl[locals[0]][VALID_F] = 1'b0;
        for (int i = 0; i < 4; i++) if (!e_ctrl[i][VALID_F]) frees.push_back(i);
        exp_ready = (frees.size() > 0);
        if (iv && exp_ready) e_ctrl[frees[0]] = iflit;
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("ctrl%0d", i), 32'(ctrl_o[i]), 32'(e_ctrl[i]));
                check($sformatf("rmatrix%0d", i), 32'(rm_o[i]), 32'(ref_rm(e_ctrl[i])));
            end
            check("inj_ready", 32'(inj_ready), 32'(exp_ready));
            check("eject_valid", 32'(eject_valid), 32'(m_ejv));
            check("eject_flit", 32'(eject_flit), 32'(m_ejf));
`ifdef ROUTE_INJECT_STARVE_EN
            check("starve", 32'(starve), 32'(m_cnt == LIMIT));
`else
            check("starve", 32'(starve), 32'(0));
`endif
        end
        nx_ejv = (locals.size() > 0);
        nx_ejf = (locals.size() > 0) ? m_slot[locals[0]] : m_ejf;
        nx_cnt = (!iv || exp_ready) ? 0 : ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
            m_ejv = 1'b0;
            m_ejf = '0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) m_slot[i] = lnk[i];
            m_ejv = nx_ejv;
            m_ejf = nx_ejf;
            m_cnt = nx_cnt;
        end
        @(negedge clk);
    endtask

    task automatic set_links(input steer_t a, input steer_t b, input steer_t c, input steer_t d);
        lnk[0] = a;
        lnk[1] = b;
        lnk[2] = c;
        lnk[3] = d;
    endtask

    steer_t l1, l3, pf, qf, lf, rf;

    initial begin
        rst    = 1'b1;
        iv     = 1'b0;
        iflit  = '0;
        chk_en = 1'b0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_ejv = 1'b0;
        m_ejf = '0;
        m_cnt = 0;

        // Reset held two cycles while links carry valid flits
        set_links(mk(1, 1, 1), mk(1, 2, 0), mk(1, 0, 3), mk(1, 3, 3));
        apply();
        advance();
        chk_en = 1'b1;
        apply();
        check("rst_inj_ready", 32'(inj_ready), 32'(1));
        check("rst_eject_valid", 32'(eject_valid), 32'(0));
        check("rst_ctrl0_valid", 32'(ctrl_o[0][VALID_F]), 32'(0));
        advance();
        rst = 1'b0;

        // Routing of non-local flits
        set_links(mk(1, 2, 1), mk(1, 1, 3), mk(1, 0, 0), mk(0, 0, 0));
        apply();
        advance();
        set_links(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
        apply();
        check("tp_rm0", 32'(rm_o[0]), 32'(4'b0100));
        check("tp_rm1", 32'(rm_o[1]), 32'(4'b1000));
        check("tp_rm2", 32'(rm_o[2]), 32'(4'b0011));
        advance();

        // Two local flits: lowest ejected, the other deflected
        l1 = mk(1, 1, 1);
        l3 = mk(1, 1, 1);
        set_links(mk(0, 1, 1), l1, mk(0, 1, 1), l3);
        apply();
        advance();
        set_links(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
        apply();
        check("tp_ctrl1_bubble", 32'(ctrl_o[1][VALID_F]), 32'(0));
        check("tp_ctrl3_valid", 32'(ctrl_o[3][VALID_F]), 32'(1));
        check("tp_rm3_local", 32'(rm_o[3]), 32'(0));
        check("tp_ready_eject", 32'(inj_ready), 32'(1));
        advance();
        apply();
        check("tp_eject_valid", 32'(eject_valid), 32'(1));
        check("tp_eject_flit", 32'(eject_flit), 32'(l1));
        advance();

        // Full slots block injection; the held flit enters slot 2 once it frees
        set_links(mk(1, 2, 1), mk(1, 0, 1), mk(1, 1, 0), mk(1, 3, 3));
        apply();
        advance();
        pf = mk(1, 3, 0);
        iv = 1'b1;
        iflit = pf;
        set_links(mk(1, 2, 2), mk(1, 0, 2), mk(0, 1, 1), mk(1, 3, 1));
        apply();
        check("tp_blocked", 32'(inj_ready), 32'(0));
        advance();
        set_links(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
        apply();
        check("tp_inj_slot2", 32'(ctrl_o[2]), 32'(pf));
        advance();
        iv = 1'b0;

        // Eject and refill slot 0 in the same cycle
        lf = mk(1, 1, 1);
        set_links(lf, mk(1, 2, 0), mk(1, 0, 2), mk(1, 3, 3));
        apply();
        advance();
        qf = mk(1, 0, 3);
        iv = 1'b1;
        iflit = qf;
        set_links(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
        apply();
        check("tp_refill_slot0", 32'(ctrl_o[0]), 32'(qf));
        advance();
        iv = 1'b0;
        apply();
        check("tp_refill_eject", 32'(eject_flit), 32'(lf));
        advance();

        // Starvation: blocked cycles then a single transfer
        set_links(mk(1, 2, 1), mk(1, 0, 1), mk(1, 1, 0), mk(1, 3, 3));
        apply();
        advance();
        rf = mk(1, 2, 3);
        iv = 1'b1;
        iflit = rf;
        for (int k = 0; k < 4; k++) begin
            set_links(mk(1, 2, 0), mk(1, 0, 2), mk(1, 3, 0), mk(1, 2, 2));
            apply();
            advance();
        end
        set_links(mk(1, 2, 0), mk(1, 0, 2), mk(1, 3, 0), mk(0, 0, 0));
        apply();
`ifdef ROUTE_INJECT_STARVE_EN
        check("tp_starve_set", 32'(starve), 32'(1));
`endif
        advance();
        set_links(mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0));
        apply();
        check("tp_starve_xfer", 32'(ctrl_o[3]), 32'(rf));
        advance();
        iv = 1'b0;
        apply();
`ifdef ROUTE_INJECT_STARVE_EN
        check("tp_starve_clr", 32'(starve), 32'(0));
`endif
        advance();

        // Random traffic; the upstream holds its flit while not accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) lnk[i] = rand_link();
            if (!(iv && !exp_ready)) begin
                iv    = ($urandom_range(2) != 0);
                iflit = mk(1, $urandom_range(3), $urandom_range(3));
            end
            if (c == 200) begin
                rst = 1'b1;
                iv  = 1'b0;
            end else begin
                rst = 1'b0;
            end
            apply();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
